imem_boot_loader: RTL and testbench

Upstream loader for the `main_MIPS_32b` single-cycle core. It receives a program image as a byte stream with a valid/ready handshake, packs the bytes into 32-bit big-endian words, and writes them into the instruction memory write port. It then verifies an XOR checksum and releases the core from reset. While loading, or after any error, it holds the core in reset, so the core never fetches from a partially loaded memory.

---
 rtl/mips_boot_pkg.sv | 24 ++
 rtl/imem_boot_loader_if.sv | 28 ++
 rtl/boot_word_packer.sv | 34 +++
 rtl/imem_boot_loader.sv | 177 +++++++++++++++++
 tb/tb_imem_boot_loader.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The loader FSM adds one internal VERIFY state between the last accepted byte and the verdict.
package mips_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN    = 3'd1,
    ST_DATA   = 3'd2,
    ST_SUM    = 3'd3,
    ST_VERIFY = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } boot_state_t;

  localparam int         LEN_BYTES      = 2;
  localparam int         BYTES_PER_WORD = 4;
  localparam logic [7:0] CSUM_OK        = 8'h00;

  // Number of words the instruction memory holds, widened so 2**16 still fits.
  function automatic logic [16:0] imem_capacity(input int addr_w);
    return 17'(1) << addr_w;
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input, instruction-memory write port and core-control outputs of the loader.
// The slave modport is the loader's view; the master modport is the stream source / observer.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
) ();

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              restart;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;

  modport master (
    output rx_data, rx_valid, restart,
    input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error
  );

  modport slave (
    input  rx_data, rx_valid, restart,
    output rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error
  );

endinterface

// File: rtl/boot_word_packer.sv
// Packs accepted bytes MSB-first into 32-bit words; flags the byte that completes a word.
// Only the first three bytes are stored: the completing byte is taken straight from the input.
module boot_word_packer
  import mips_boot_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [23:0] r_shift;
  logic [1:0]  r_byte_cnt;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_shift    <= '0;
      r_byte_cnt <= '0;
    end else if (i_clear) begin
      r_shift    <= '0;
      r_byte_cnt <= '0;
    end else if (i_byte_valid) begin
      r_shift    <= {r_shift[15:0], i_byte};
      r_byte_cnt <= r_byte_cnt + 2'd1;
    end
  end

  assign o_word_valid = i_byte_valid && (r_byte_cnt == 2'(BYTES_PER_WORD - 1));
  assign o_word       = {r_shift, i_byte};

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory and
// holds the core in reset until the whole image has been written and the checksum verified.
module imem_boot_loader
  import mips_boot_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input logic               clock,
  input logic               reset,
  imem_boot_loader_if.slave bus
);

  localparam int          CW       = ADDR_W + 1;
  localparam logic [16:0] CAPACITY = imem_capacity(ADDR_W);

  boot_state_t r_state;
  boot_state_t w_state_next;

  logic              r_len_idx;
  logic [7:0]        r_len_hi;
  logic [15:0]       r_word_total;
  logic [CW-1:0]     r_word_cnt;
  logic [7:0]        r_xor;
  logic              r_fail;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]       r_imem_wdata;

  logic        w_rx_ready;
  logic        w_cpu_reset;
  logic        w_done;
  logic        w_error;
  logic        w_accept;
  logic        w_clear;
  logic        w_pack_valid;
  logic        w_word_valid;
  logic [31:0] w_word;
  logic        w_len_last;
  logic [15:0] w_len_value;
  logic        w_len_oversize;
  logic        w_last_word;
  logic [7:0]  w_sum_final;

  assign w_accept       = bus.rx_valid && w_rx_ready;
  assign w_clear        = (r_state == ST_IDLE);
  assign w_pack_valid   = w_accept && (r_state == ST_DATA);
  assign w_len_last     = (r_len_idx == 1'(LEN_BYTES - 1));
  assign w_len_value    = {r_len_hi, bus.rx_data};
  assign w_len_oversize = ({1'b0, w_len_value} > CAPACITY);
  assign w_last_word    = ((17'(r_word_cnt) + 17'd1) == {1'b0, r_word_total});
  assign w_sum_final    = r_xor ^ bus.rx_data;

  boot_word_packer u_packer (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_clear      (w_clear),
    .i_byte_valid (w_pack_valid),
    .i_byte       (bus.rx_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Checks that decide the verdict are registered in r_fail and acted on one edge later.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: w_state_next = ST_LEN;
      ST_LEN: begin
        if (w_accept && w_len_last) begin
          if (w_len_oversize) begin
            w_state_next = ST_VERIFY;
          end else if (w_len_value == 16'd0) begin
            w_state_next = ST_SUM;
          end else begin
            w_state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_word_valid && w_last_word) begin
          w_state_next = ST_SUM;
        end
      end
      ST_SUM: begin
        if (w_accept) begin
          w_state_next = ST_VERIFY;
        end
      end
      ST_VERIFY: w_state_next = r_fail ? ST_ERROR : ST_DONE;
      ST_DONE, ST_ERROR: begin
        if (bus.restart) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rx_ready  = 1'b0;
    w_cpu_reset = 1'b1;
    w_done      = 1'b0;
    w_error     = 1'b0;
    case (r_state)
      ST_LEN, ST_DATA, ST_SUM: w_rx_ready = 1'b1;
      ST_DONE: begin
        w_cpu_reset = 1'b0;
        w_done      = 1'b1;
      end
      ST_ERROR: w_error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_len_idx    <= 1'b0;
      r_len_hi     <= '0;
      r_word_total <= '0;
      r_word_cnt   <= '0;
      r_xor        <= '0;
      r_fail       <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
    end else begin
      if (w_clear) begin
        r_len_idx  <= 1'b0;
        r_word_cnt <= '0;
        r_xor      <= '0;
        r_fail     <= 1'b0;
      end else begin
        if (w_accept) begin
          r_xor <= r_xor ^ bus.rx_data;
        end
        if (w_accept && (r_state == ST_LEN)) begin
          r_len_idx <= r_len_idx + 1'b1;
          if (!w_len_last) begin
            r_len_hi <= bus.rx_data;
          end else begin
            r_word_total <= w_len_value;
            r_fail       <= w_len_oversize;
          end
        end
        if (w_word_valid) begin
          r_word_cnt <= r_word_cnt + CW'(1);
        end
        if (w_accept && (r_state == ST_SUM)) begin
          r_fail <= (w_sum_final != CSUM_OK);
        end
      end
      // Memory is written as words complete; the checksum only gates core release.
      r_imem_we <= w_word_valid;
      if (w_word_valid) begin
        r_imem_addr  <= r_word_cnt[ADDR_W-1:0];
        r_imem_wdata <= w_word;
      end
    end
  end

  assign bus.rx_ready   = w_rx_ready;
  assign bus.cpu_reset  = w_cpu_reset;
  assign bus.done       = w_done;
  assign bus.error      = w_error;
  assign bus.imem_we    = r_imem_we;
  assign bus.imem_addr  = r_imem_addr;
  assign bus.imem_wdata = r_imem_wdata;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized self-checking bench for imem_boot_loader: streams are built from word lists,
// and expected writes/verdicts come from the stream rules rather than the loader's internals.
module tb_imem_boot_loader;

  localparam int AW  = 8;
  localparam int CAP = 1 << AW;

  typedef logic [7:0]  byteq_t[$];
  typedef logic [31:0] wordq_t[$];

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [AW+31:0] obs_q[$];

  imem_boot_loader_if #(.ADDR_W(AW)) bus ();

  imem_boot_loader #(.ADDR_W(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (bus.imem_we === 1'b1) obs_q.push_back({bus.imem_addr, bus.imem_wdata});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit (got running, required finished)");
    $fatal(1, "watchdog expired");
  end

  function automatic byteq_t make_stream(input wordq_t w, input bit corrupt);
    byteq_t     s;
    logic [15:0] n;
    logic [7:0]  x;
    n = 16'(w.size());
    s.push_back(n[15:8]);
    s.push_back(n[7:0]);
    foreach (w[i]) for (int b = 3; b >= 0; b--) s.push_back(w[i][8*b +: 8]);
    x = 8'h00;
    foreach (s[i]) x = x ^ s[i];
    s.push_back(corrupt ? (x ^ 8'h01) : x);
    return s;
  endfunction

  task automatic send_bytes(input byteq_t s, input int gap_pct, output bit ok);
    int idx = 0;
    int cyc = 0;
    while (idx < s.size() && cyc < 5000) begin
      @(negedge clock);
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        bus.rx_valid = 1'b0;
      end else begin
        bus.rx_valid = 1'b1;
        bus.rx_data  = s[idx];
        if (bus.rx_ready === 1'b1) idx++;
      end
      cyc++;
    end
    @(posedge clock);
    #1;
    bus.rx_valid = 1'b0;
    ok = (idx == s.size());
  endtask

  task automatic pulse_restart;
    @(negedge clock);
    bus.restart = 1'b1;
    @(negedge clock);
    bus.restart = 1'b0;
  endtask

  task automatic test_image(input string name, input wordq_t w, input bit corrupt, input int gap);
    byteq_t         s;
    bit             ok;
    bit             good;
    logic [AW-1:0]  a;
    logic [AW+31:0] exp;
    s    = make_stream(w, corrupt);
    good = !corrupt;
    obs_q.delete();
    send_bytes(s, gap, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s stream_accept: got timeout, required all %0d bytes accepted", name, s.size());
    end
    n_checks++;
    if (bus.done !== 1'b0 || bus.error !== 1'b0 || bus.cpu_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL %s verdict_latency: got done=%b error=%b cpu_reset=%b, required 0/0/1 one edge after C",
               name, bus.done, bus.error, bus.cpu_reset);
    end
    @(posedge clock);
    #1;
    n_checks++;
    if (bus.done !== good || bus.error !== !good || bus.cpu_reset !== !good || bus.rx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s verdict: got done=%b error=%b cpu_reset=%b rx_ready=%b, required %b/%b/%b/0",
               name, bus.done, bus.error, bus.cpu_reset, bus.rx_ready, good, !good, !good);
    end
    n_checks++;
    if (obs_q.size() != w.size()) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d, required %0d", name, obs_q.size(), w.size());
    end else begin
      foreach (w[i]) begin
        a   = AW'(i);
        exp = {a, w[i]};
        n_checks++;
        if (obs_q[i] !== exp) begin
          n_fail++;
          $display("FAIL %s write[%0d]: got addr=%0h data=%08h, required addr=%0h data=%08h",
                   name, i, obs_q[i][AW+31:32], obs_q[i][31:0], a, w[i]);
        end
      end
    end
    $display("%s: N=%0d corrupt=%0d gap=%0d writes=%0d done=%b error=%b",
             name, w.size(), corrupt, gap, obs_q.size(), bus.done, bus.error);
  endtask

  task automatic test_reset;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hAA;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if (bus.rx_ready !== 1'b0 || bus.imem_we !== 1'b0 || bus.imem_addr !== '0 || bus.imem_wdata !== 32'h0 ||
        bus.cpu_reset !== 1'b1 || bus.done !== 1'b0 || bus.error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got ready=%b we=%b addr=%0h wdata=%0h cpu_reset=%b done=%b error=%b, required 0/0/0/0/1/0/0",
               bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.cpu_reset, bus.done, bus.error);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.rx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL first_edge_ready: got %b, required 0 before first edge after reset", bus.rx_ready);
    end
    @(posedge clock);
    #1;
    bus.rx_valid = 1'b0;
    n_checks++;
    if (bus.rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL len_ready: got %b, required 1 after first edge", bus.rx_ready);
    end
    $display("reset: outputs checked, rx_ready=%b after first edge", bus.rx_ready);
  endtask

  task automatic test_good_load;
    wordq_t w = '{32'h20080005, 32'h2009000A};
    test_image("good_load", w, 1'b0, 0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h55;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      n_checks++;
      if (bus.rx_ready !== 1'b0 || bus.done !== 1'b1) begin
        n_fail++;
        $display("FAIL done_hold: got rx_ready=%b done=%b, required 0/1", bus.rx_ready, bus.done);
      end
    end
    bus.rx_valid = 1'b0;
    n_checks++;
    if (obs_q.size() != 2) begin
      n_fail++;
      $display("FAIL done_no_write: got %0d writes, required 2", obs_q.size());
    end
    $display("done_hold: 6 cycles with rx_valid=1, writes=%0d", obs_q.size());
    pulse_restart();
  endtask

  task automatic test_bad_checksum;
    wordq_t w = '{32'h20080005, 32'h2009000A};
    test_image("bad_checksum", w, 1'b1, 0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h0C;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      n_checks++;
      if (bus.rx_ready !== 1'b0 || bus.error !== 1'b1 || bus.cpu_reset !== 1'b1) begin
        n_fail++;
        $display("FAIL error_hold: got rx_ready=%b error=%b cpu_reset=%b, required 0/1/1",
                 bus.rx_ready, bus.error, bus.cpu_reset);
      end
    end
    bus.rx_valid = 1'b0;
    $display("error_hold: 6 cycles with rx_valid=1, error=%b", bus.error);
    pulse_restart();
  endtask

  task automatic test_oversize;
    byteq_t s = '{8'h01, 8'h01};
    bit ok;
    obs_q.delete();
    send_bytes(s, 0, ok);
    n_checks++;
    if (!ok || bus.error !== 1'b0) begin
      n_fail++;
      $display("FAIL oversize_latency: got ok=%b error=%b, required 1/0 right after LEN_LO", ok, bus.error);
    end
    @(posedge clock);
    #1;
    n_checks++;
    if (bus.error !== 1'b1 || bus.cpu_reset !== 1'b1 || bus.rx_ready !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL oversize_error: got error=%b cpu_reset=%b rx_ready=%b done=%b, required 1/1/0/0",
               bus.error, bus.cpu_reset, bus.rx_ready, bus.done);
    end
    repeat (5) @(posedge clock);
    #1;
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL oversize_writes: got %0d, required 0", obs_q.size());
    end
    $display("oversize: N=257 error=%b writes=%0d", bus.error, obs_q.size());
    pulse_restart();
  endtask

  task automatic test_empty_and_full;
    wordq_t w;
    test_image("empty", w, 1'b0, 0);
    pulse_restart();
    for (int i = 0; i < CAP; i++) w.push_back($urandom);
    test_image("full", w, 1'b0, 0);
    pulse_restart();
  endtask

  task automatic test_random_gaps;
    wordq_t w = '{32'h20080005, 32'h2009000A};
    test_image("gaps_scen1", w, 1'b0, 40);
    pulse_restart();
    for (int k = 0; k < 6; k++) begin
      wordq_t r;
      int n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) r.push_back($urandom);
      test_image($sformatf("random%0d", k), r, ($urandom_range(0, 3) == 0), $urandom_range(0, 50));
      pulse_restart();
    end
  endtask

  task automatic test_reset_midload_restart;
    wordq_t w = '{32'h20080005, 32'h2009000A};
    wordq_t r;
    byteq_t s;
    byteq_t part;
    bit ok;
    s    = make_stream(w, 1'b0);
    part = s[0:5];
    send_bytes(part, 0, ok);
    n_checks++;
    if (!ok || bus.imem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL midload_write: got ok=%b imem_we=%b, required 1/1 after first word", ok, bus.imem_we);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.imem_we !== 1'b0 || bus.imem_addr !== '0 || bus.imem_wdata !== 32'h0 ||
        bus.rx_ready !== 1'b0 || bus.cpu_reset !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got we=%b addr=%0h wdata=%0h ready=%b cpu_reset=%b done=%b, required 0/0/0/0/1/0",
               bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.rx_ready, bus.cpu_reset, bus.done);
    end
    $display("midload_reset: reset asserted with write in flight, imem_we=%b", bus.imem_we);
    @(negedge clock);
    reset = 1'b0;
    test_image("after_reset", w, 1'b0, 0);
    @(negedge clock);
    bus.restart  = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hFF;
    @(posedge clock);
    #1;
    n_checks++;
    if (bus.cpu_reset !== 1'b1 || bus.done !== 1'b0 || bus.rx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_edge: got cpu_reset=%b done=%b rx_ready=%b, required 1/0/0",
               bus.cpu_reset, bus.done, bus.rx_ready);
    end
    @(negedge clock);
    bus.restart = 1'b0;
    @(posedge clock);
    #1;
    bus.rx_valid = 1'b0;
    n_checks++;
    if (bus.rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_ready: got %b, required 1 one cycle after restart", bus.rx_ready);
    end
    $display("restart: cpu_reset=1 done=0 next edge, rx_ready=%b one cycle later", bus.rx_ready);
    for (int i = 0; i < 5; i++) r.push_back($urandom);
    test_image("second_load", r, 1'b0, 20);
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.restart  = 1'b0;
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_oversize();
    test_empty_and_full();
    test_random_gaps();
    test_reset_midload_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
